vai_rx_demux: RTL and testbench

VAI_RX_DEMUX -- requirements
Module: vai_rx_demux

---
 rtl/vai_rx_demux.sv | 227 ++++++++++++++++++++++
 tb/tb_vai_rx_demux.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vai_rx_demux.sv
// Upstream c0/c1 response and MMIO request demultiplexer: routes each event to one
// of NUM_SUB_AFUS sub-AFU ports through a fixed two-stage pipeline and counts drops.

module vai_rx_demux_lane (
    input  logic        clk,
    input  logic        rst,
    input  logic        c0_hit,
    input  logic        c1_hit,
    input  logic        rd_hit,
    input  logic        wr_hit,
    input  logic        up_c0_alm,
    input  logic        up_c1_alm,
    output logic        c0_stb,
    output logic        c1_stb,
    output logic        rd_stb,
    output logic        wr_stb,
    output logic        c0_alm,
    output logic        c1_alm,
    output logic [31:0] rsp_cnt
);
    logic [31:0] cnt;
    logic        c0_alm_q;
    logic        c1_alm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            c0_stb   <= 1'b0;
            c1_stb   <= 1'b0;
            rd_stb   <= 1'b0;
            wr_stb   <= 1'b0;
            cnt      <= '0;
            c0_alm_q <= 1'b1;
            c1_alm_q <= 1'b1;
        end else begin
            c0_stb   <= c0_hit;
            c1_stb   <= c1_hit;
            rd_stb   <= rd_hit;
            wr_stb   <= wr_hit;
            // counts on the same edge the strobe rises, so it tracks the strobe exactly
            cnt      <= cnt + 32'(c0_hit);
            c0_alm_q <= up_c0_alm;
            c1_alm_q <= up_c1_alm;
        end
    end

    // almost-full is forced high for the whole time reset is held
    assign c0_alm  = c0_alm_q | rst;
    assign c1_alm  = c1_alm_q | rst;
    assign rsp_cnt = cnt;
endmodule

module vai_rx_demux #(
    parameter int NUM_SUB_AFUS = 9,
    parameter int TAG_LSB      = 12
) (
    input  logic                       pClk,
    input  logic                       SoftReset,
    input  logic                       up_c0_valid,
    input  logic [3:0]                 up_c0_resp_type,
    input  logic [15:0]                up_c0_mdata,
    input  logic [1:0]                 up_c0_cl_num,
    input  logic [511:0]               up_c0_data,
    input  logic                       up_c1_valid,
    input  logic [3:0]                 up_c1_resp_type,
    input  logic [15:0]                up_c1_mdata,
    input  logic                       up_mmio_rd,
    input  logic                       up_mmio_wr,
    input  logic [15:0]                up_mmio_addr,
    input  logic [8:0]                 up_mmio_tid,
    input  logic [63:0]                up_mmio_data,
    input  logic                       up_c0TxAlmFull,
    input  logic                       up_c1TxAlmFull,
    input  logic [NUM_SUB_AFUS-1:0]    afu_in_reset,
    output logic [NUM_SUB_AFUS-1:0]    afu_c0_valid,
    output logic [NUM_SUB_AFUS-1:0]    afu_c1_valid,
    output logic [NUM_SUB_AFUS-1:0]    afu_mmio_rd,
    output logic [NUM_SUB_AFUS-1:0]    afu_mmio_wr,
    output logic [3:0]                 dn_c0_resp_type,
    output logic [15:0]                dn_c0_mdata,
    output logic [1:0]                 dn_c0_cl_num,
    output logic [511:0]               dn_c0_data,
    output logic [3:0]                 dn_c1_resp_type,
    output logic [15:0]                dn_c1_mdata,
    output logic [11:0]                dn_mmio_addr,
    output logic [8:0]                 dn_mmio_tid,
    output logic [63:0]                dn_mmio_data,
    output logic [NUM_SUB_AFUS-1:0]    afu_c0TxAlmFull,
    output logic [NUM_SUB_AFUS-1:0]    afu_c1TxAlmFull,
    output logic [31:0]                drop_cnt,
    output logic [NUM_SUB_AFUS*32-1:0] c0_rsp_cnt
);
    localparam logic [15:0] TAG_MASK = 16'hF << TAG_LSB;
    localparam logic [3:0]  NUM4     = 4'(NUM_SUB_AFUS);

    // channel bit positions in the per-stage valid vectors
    localparam int CH_C0 = 0;
    localparam int CH_C1 = 1;
    localparam int CH_MM = 2;

    // ---------------- decode ----------------
    logic [15:0] in_rst;
    logic [3:0]  c0_idx;
    logic [3:0]  c1_idx;
    logic [3:0]  mm_win;
    logic [3:0]  mm_idx;
    logic        c0_ok;
    logic        c1_ok;
    logic        mm_vld;
    logic        mm_ok;

    always_comb begin
        // zero-extended so any 4-bit index is a safe lookup
        in_rst = 16'(afu_in_reset);
        c0_idx = up_c0_mdata[TAG_LSB +: 4];
        c1_idx = up_c1_mdata[TAG_LSB +: 4];
        mm_win = up_mmio_addr[15:12];
        mm_idx = mm_win - 4'd1;
        c0_ok  = (c0_idx < NUM4) && !in_rst[c0_idx];
        c1_ok  = (c1_idx < NUM4) && !in_rst[c1_idx];
        // window 0 belongs to someone else: not an event here, not a drop
        mm_vld = (up_mmio_rd || up_mmio_wr) && (mm_win != 4'd0);
        mm_ok  = !(up_mmio_rd && up_mmio_wr) && (mm_win <= NUM4) && !in_rst[mm_idx];
    end

    // ---------------- stage 1 ----------------
    logic [2:0]   s1_vld;
    logic [2:0]   s1_ok;
    logic [2:0]   s1_go;
    logic [2:0]   s1_drop;
    logic [3:0]   s1_c0_idx;
    logic [3:0]   s1_c0_type;
    logic [15:0]  s1_c0_mdata;
    logic [1:0]   s1_c0_cl;
    logic [511:0] s1_c0_data;
    logic [3:0]   s1_c1_idx;
    logic [3:0]   s1_c1_type;
    logic [15:0]  s1_c1_mdata;
    logic [3:0]   s1_mm_idx;
    logic         s1_mm_wr;
    logic [11:0]  s1_mm_addr;
    logic [8:0]   s1_mm_tid;
    logic [63:0]  s1_mm_data;

    assign s1_go   = s1_vld & s1_ok;
    assign s1_drop = s1_vld & ~s1_ok;

    always_ff @(posedge pClk) begin
        if (SoftReset) begin
            s1_vld   <= '0;
            s1_ok    <= '0;
            drop_cnt <= '0;
        end else begin
            s1_vld[CH_C0] <= up_c0_valid;
            s1_vld[CH_C1] <= up_c1_valid;
            s1_vld[CH_MM] <= mm_vld;
            s1_ok[CH_C0]  <= c0_ok;
            s1_ok[CH_C1]  <= c1_ok;
            s1_ok[CH_MM]  <= mm_ok;
            drop_cnt      <= drop_cnt + 32'(s1_drop[CH_C0]) + 32'(s1_drop[CH_C1])
                                      + 32'(s1_drop[CH_MM]);
        end
    end

    // payload and index carry no reset: they are only looked at behind s1_vld
    always_ff @(posedge pClk) begin
        if (up_c0_valid) begin
            s1_c0_idx   <= c0_idx;
            s1_c0_type  <= up_c0_resp_type;
            s1_c0_mdata <= up_c0_mdata & ~TAG_MASK;
            s1_c0_cl    <= up_c0_cl_num;
            s1_c0_data  <= up_c0_data;
        end
        if (up_c1_valid) begin
            s1_c1_idx   <= c1_idx;
            s1_c1_type  <= up_c1_resp_type;
            s1_c1_mdata <= up_c1_mdata & ~TAG_MASK;
        end
        if (up_mmio_rd || up_mmio_wr) begin
            s1_mm_idx  <= mm_idx;
            s1_mm_wr   <= up_mmio_wr;
            s1_mm_addr <= up_mmio_addr[11:0];
            s1_mm_tid  <= up_mmio_tid;
            s1_mm_data <= up_mmio_data;
        end
    end

    // ---------------- stage 2: shared payload buses ----------------
    // loaded only on delivery so the buses hold between strobes
    always_ff @(posedge pClk) begin
        if (s1_go[CH_C0]) begin
            dn_c0_resp_type <= s1_c0_type;
            dn_c0_mdata     <= s1_c0_mdata;
            dn_c0_cl_num    <= s1_c0_cl;
            dn_c0_data      <= s1_c0_data;
        end
        if (s1_go[CH_C1]) begin
            dn_c1_resp_type <= s1_c1_type;
            dn_c1_mdata     <= s1_c1_mdata;
        end
        if (s1_go[CH_MM]) begin
            dn_mmio_addr <= s1_mm_addr;
            dn_mmio_tid  <= s1_mm_tid;
            dn_mmio_data <= s1_mm_data;
        end
    end

    // ---------------- stage 2: per-AFU strobes, counters, back-pressure ----------------
    for (genvar i = 0; i < NUM_SUB_AFUS; i++) begin : g_lane
        vai_rx_demux_lane u_lane (
            .clk       (pClk),
            .rst       (SoftReset),
            .c0_hit    (s1_go[CH_C0] && (s1_c0_idx == 4'(i))),
            .c1_hit    (s1_go[CH_C1] && (s1_c1_idx == 4'(i))),
            .rd_hit    (s1_go[CH_MM] && !s1_mm_wr && (s1_mm_idx == 4'(i))),
            .wr_hit    (s1_go[CH_MM] &&  s1_mm_wr && (s1_mm_idx == 4'(i))),
            .up_c0_alm (up_c0TxAlmFull),
            .up_c1_alm (up_c1TxAlmFull),
            .c0_stb    (afu_c0_valid[i]),
            .c1_stb    (afu_c1_valid[i]),
            .rd_stb    (afu_mmio_rd[i]),
            .wr_stb    (afu_mmio_wr[i]),
            .c0_alm    (afu_c0TxAlmFull[i]),
            .c1_alm    (afu_c1TxAlmFull[i]),
            .rsp_cnt   (c0_rsp_cnt[i*32 +: 32])
        );
    end
endmodule

// File: tb/tb_vai_rx_demux.sv
// Bench for vai_rx_demux: directed scenarios with known answers, then randomized
// traffic checked against an event-level reference model.

module tb_vai_rx_demux;
    localparam int N = 9;

    logic           pClk = 1'b0;
    logic           SoftReset;
    logic           up_c0_valid;
    logic [3:0]     up_c0_resp_type;
    logic [15:0]    up_c0_mdata;
    logic [1:0]     up_c0_cl_num;
    logic [511:0]   up_c0_data;
    logic           up_c1_valid;
    logic [3:0]     up_c1_resp_type;
    logic [15:0]    up_c1_mdata;
    logic           up_mmio_rd;
    logic           up_mmio_wr;
    logic [15:0]    up_mmio_addr;
    logic [8:0]     up_mmio_tid;
    logic [63:0]    up_mmio_data;
    logic           up_c0TxAlmFull;
    logic           up_c1TxAlmFull;
    logic [N-1:0]   afu_in_reset;
    logic [N-1:0]   afu_c0_valid;
    logic [N-1:0]   afu_c1_valid;
    logic [N-1:0]   afu_mmio_rd;
    logic [N-1:0]   afu_mmio_wr;
    logic [3:0]     dn_c0_resp_type;
    logic [15:0]    dn_c0_mdata;
    logic [1:0]     dn_c0_cl_num;
    logic [511:0]   dn_c0_data;
    logic [3:0]     dn_c1_resp_type;
    logic [15:0]    dn_c1_mdata;
    logic [11:0]    dn_mmio_addr;
    logic [8:0]     dn_mmio_tid;
    logic [63:0]    dn_mmio_data;
    logic [N-1:0]   afu_c0TxAlmFull;
    logic [N-1:0]   afu_c1TxAlmFull;
    logic [31:0]    drop_cnt;
    logic [N*32-1:0] c0_rsp_cnt;

    int checks = 0;
    int errors = 0;

    always #5 pClk = ~pClk;

    vai_rx_demux #(.NUM_SUB_AFUS(N), .TAG_LSB(12)) dut (
        .pClk(pClk), .SoftReset(SoftReset),
        .up_c0_valid(up_c0_valid), .up_c0_resp_type(up_c0_resp_type),
        .up_c0_mdata(up_c0_mdata), .up_c0_cl_num(up_c0_cl_num), .up_c0_data(up_c0_data),
        .up_c1_valid(up_c1_valid), .up_c1_resp_type(up_c1_resp_type), .up_c1_mdata(up_c1_mdata),
        .up_mmio_rd(up_mmio_rd), .up_mmio_wr(up_mmio_wr), .up_mmio_addr(up_mmio_addr),
        .up_mmio_tid(up_mmio_tid), .up_mmio_data(up_mmio_data),
        .up_c0TxAlmFull(up_c0TxAlmFull), .up_c1TxAlmFull(up_c1TxAlmFull),
        .afu_in_reset(afu_in_reset),
        .afu_c0_valid(afu_c0_valid), .afu_c1_valid(afu_c1_valid),
        .afu_mmio_rd(afu_mmio_rd), .afu_mmio_wr(afu_mmio_wr),
        .dn_c0_resp_type(dn_c0_resp_type), .dn_c0_mdata(dn_c0_mdata),
        .dn_c0_cl_num(dn_c0_cl_num), .dn_c0_data(dn_c0_data),
        .dn_c1_resp_type(dn_c1_resp_type), .dn_c1_mdata(dn_c1_mdata),
        .dn_mmio_addr(dn_mmio_addr), .dn_mmio_tid(dn_mmio_tid), .dn_mmio_data(dn_mmio_data),
        .afu_c0TxAlmFull(afu_c0TxAlmFull), .afu_c1TxAlmFull(afu_c1TxAlmFull),
        .drop_cnt(drop_cnt), .c0_rsp_cnt(c0_rsp_cnt)
    );

    // expected visible state of the outputs after a given edge
    typedef struct packed {
        logic [N-1:0]    c0v;
        logic [N-1:0]    c1v;
        logic [N-1:0]    rd;
        logic [N-1:0]    wr;
        logic [31:0]     drop;
        logic [N*32-1:0] cnt;
        logic            lv0;
        logic            lv1;
        logic            lvm;
        logic [3:0]      c0_type;
        logic [15:0]     c0_md;
        logic [1:0]      c0_cl;
        logic [511:0]    c0_d;
        logic [3:0]      c1_type;
        logic [15:0]     c1_md;
        logic [11:0]     m_addr;
        logic [8:0]      m_tid;
        logic [63:0]     m_data;
    } exp_t;

    task automatic tick();
        @(posedge pClk);
        #1;
    endtask

    task automatic idle();
        up_c0_valid  = 1'b0;
        up_c1_valid  = 1'b0;
        up_mmio_rd   = 1'b0;
        up_mmio_wr   = 1'b0;
        afu_in_reset = '0;
    endtask

    task automatic do_reset();
        SoftReset = 1'b1;
        idle();
        tick();
        tick();
        SoftReset = 1'b0;
    endtask

    task automatic test_reset();
        SoftReset = 1'b1;
        idle();
        up_c0TxAlmFull = 1'b0;
        up_c1TxAlmFull = 1'b0;
        up_c0_valid = 1'b1;
        up_c0_mdata = 16'h1000;
        tick();
        tick();
        checks++; if (afu_c0_valid !== '0) begin errors++; $display("FAIL reset_strobe: got %h want 0", afu_c0_valid); end
        checks++; if (drop_cnt !== 32'd0) begin errors++; $display("FAIL reset_drop: got %h want 0", drop_cnt); end
        checks++; if (c0_rsp_cnt !== '0) begin errors++; $display("FAIL reset_rspcnt: got %h want 0", c0_rsp_cnt); end
        checks++; if (afu_c0TxAlmFull !== {N{1'b1}}) begin errors++; $display("FAIL reset_alm0: got %h want 1ff", afu_c0TxAlmFull); end
        checks++; if (afu_c1TxAlmFull !== {N{1'b1}}) begin errors++; $display("FAIL reset_alm1: got %h want 1ff", afu_c1TxAlmFull); end
        SoftReset = 1'b0;
        idle();
        tick();
        checks++; if (afu_c0TxAlmFull !== '0) begin errors++; $display("FAIL alm0_follow: got %h want 0", afu_c0TxAlmFull); end
        up_c0TxAlmFull = 1'b1;
        afu_in_reset = '1;
        tick();
        checks++; if (afu_c0TxAlmFull !== {N{1'b1}}) begin errors++; $display("FAIL alm0_delay: got %h want 1ff", afu_c0TxAlmFull); end
        checks++; if (afu_c1TxAlmFull !== '0) begin errors++; $display("FAIL alm1_indep: got %h want 0", afu_c1TxAlmFull); end
        up_c0TxAlmFull = 1'b0;
        idle();
    endtask

    task automatic test_c0_route();
        logic [511:0] d;
        do_reset();
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
        up_c0_valid = 1'b1;
        up_c0_mdata = 16'h3ABC;
        up_c0_resp_type = 4'h3;
        up_c0_cl_num = 2'd2;
        up_c0_data = d;
        tick();
        idle();
        checks++; if (afu_c0_valid !== '0) begin errors++; $display("FAIL c0_latency: got %h want 0", afu_c0_valid); end
        tick();
        checks++; if (afu_c0_valid !== 9'h008) begin errors++; $display("FAIL c0_strobe: got %h want 008", afu_c0_valid); end
        checks++; if (dn_c0_mdata !== 16'h0ABC) begin errors++; $display("FAIL c0_mdata: got %h want 0abc", dn_c0_mdata); end
        checks++; if (dn_c0_data !== d) begin errors++; $display("FAIL c0_data: got %h want %h", dn_c0_data, d); end
        checks++; if ({dn_c0_resp_type, dn_c0_cl_num} !== 6'b0011_10) begin errors++; $display("FAIL c0_type_cl: got %h/%h want 3/2", dn_c0_resp_type, dn_c0_cl_num); end
        checks++; if (c0_rsp_cnt[3*32 +: 32] !== 32'd1) begin errors++; $display("FAIL c0_cnt3: got %h want 1", c0_rsp_cnt[3*32 +: 32]); end
        tick();
        checks++; if (afu_c0_valid !== '0) begin errors++; $display("FAIL c0_single: got %h want 0", afu_c0_valid); end
        checks++; if (dn_c0_mdata !== 16'h0ABC) begin errors++; $display("FAIL c0_hold: got %h want 0abc", dn_c0_mdata); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        up_c0_valid = 1'b1;
        up_c0_mdata = 16'h3001;
        tick();
        up_c0_mdata = 16'h3002;
        tick();
        checks++; if ({afu_c0_valid, dn_c0_mdata} !== {9'h008, 16'h0001}) begin errors++; $display("FAIL b2b_first: got %h/%h want 008/0001", afu_c0_valid, dn_c0_mdata); end
        up_c0_mdata = 16'h0003;
        tick();
        idle();
        checks++; if ({afu_c0_valid, dn_c0_mdata} !== {9'h008, 16'h0002}) begin errors++; $display("FAIL b2b_second: got %h/%h want 008/0002", afu_c0_valid, dn_c0_mdata); end
        tick();
        checks++; if ({afu_c0_valid, dn_c0_mdata} !== {9'h001, 16'h0003}) begin errors++; $display("FAIL b2b_third: got %h/%h want 001/0003", afu_c0_valid, dn_c0_mdata); end
        tick();
        checks++; if ({c0_rsp_cnt[3*32 +: 32], c0_rsp_cnt[31:0]} !== {32'd2, 32'd1}) begin errors++; $display("FAIL b2b_cnt: got %h/%h want 2/1", c0_rsp_cnt[3*32 +: 32], c0_rsp_cnt[31:0]); end
    endtask

    task automatic test_c1_drop();
        do_reset();
        up_c1_valid = 1'b1;
        up_c1_mdata = 16'hC001;
        tick();
        up_c1_mdata = 16'h9000;
        tick();
        idle();
        checks++; if (afu_c1_valid !== '0) begin errors++; $display("FAIL c1_idx12: got %h want 0", afu_c1_valid); end
        checks++; if (drop_cnt !== 32'd1) begin errors++; $display("FAIL c1_drop1: got %h want 1", drop_cnt); end
        tick();
        checks++; if (afu_c1_valid !== '0) begin errors++; $display("FAIL c1_idx9: got %h want 0", afu_c1_valid); end
        checks++; if (drop_cnt !== 32'd2) begin errors++; $display("FAIL c1_drop2: got %h want 2", drop_cnt); end
    endtask

    task automatic test_mmio();
        do_reset();
        up_mmio_wr = 1'b1; up_mmio_addr = 16'h2040; up_mmio_data = 64'h55; up_mmio_tid = 9'h1A5;
        tick(); idle(); tick();
        checks++; if ({afu_mmio_wr, afu_mmio_rd} !== {9'h002, 9'h000}) begin errors++; $display("FAIL mmio_wr: got %h/%h want 002/000", afu_mmio_wr, afu_mmio_rd); end
        checks++; if ({dn_mmio_addr, dn_mmio_tid, dn_mmio_data} !== {12'h040, 9'h1A5, 64'h55}) begin errors++; $display("FAIL mmio_payload: got %h/%h/%h want 040/1a5/55", dn_mmio_addr, dn_mmio_tid, dn_mmio_data); end
        up_mmio_wr = 1'b1; up_mmio_addr = 16'h0040;
        tick(); idle(); tick();
        checks++; if ({afu_mmio_wr, drop_cnt} !== {9'h000, 32'd0}) begin errors++; $display("FAIL mmio_win0: got %h/%h want 000/0", afu_mmio_wr, drop_cnt); end
        up_mmio_rd = 1'b1; up_mmio_addr = 16'h9FFC; up_mmio_tid = 9'h007;
        tick(); idle(); tick();
        checks++; if ({afu_mmio_rd, dn_mmio_addr} !== {9'h100, 12'hFFC}) begin errors++; $display("FAIL mmio_win9: got %h/%h want 100/ffc", afu_mmio_rd, dn_mmio_addr); end
        up_mmio_rd = 1'b1; up_mmio_wr = 1'b1; up_mmio_addr = 16'h3000;
        tick(); idle(); tick();
        checks++; if ({afu_mmio_rd, afu_mmio_wr, drop_cnt} !== {9'h000, 9'h000, 32'd1}) begin errors++; $display("FAIL mmio_rdwr: got %h/%h/%h want 000/000/1", afu_mmio_rd, afu_mmio_wr, drop_cnt); end
        up_mmio_wr = 1'b1; up_mmio_addr = 16'hA000;
        tick(); idle(); tick();
        checks++; if ({afu_mmio_wr, drop_cnt} !== {9'h000, 32'd2}) begin errors++; $display("FAIL mmio_win10: got %h/%h want 000/2", afu_mmio_wr, drop_cnt); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            up_c0_valid = 1'b1; up_c0_mdata = 16'h0123;
            up_c1_valid = 1'b1; up_c1_mdata = 16'h8777;
            up_mmio_rd  = 1'b1; up_mmio_addr = 16'h5004;
            afu_in_reset = (pass == 1) ? 9'h001 : 9'h000;
            tick(); idle(); tick();
            checks++;
            if ({afu_c0_valid, afu_c1_valid, afu_mmio_rd} !== {((pass == 1) ? 9'h000 : 9'h001), 9'h100, 9'h010}) begin
                errors++; $display("FAIL same_cycle_p%0d: got %h/%h/%h", pass, afu_c0_valid, afu_c1_valid, afu_mmio_rd);
            end
            checks++; if (dn_c1_mdata !== 16'h0777) begin errors++; $display("FAIL same_cycle_c1md: got %h want 0777", dn_c1_mdata); end
            checks++; if (drop_cnt !== 32'(pass)) begin errors++; $display("FAIL same_cycle_drop_p%0d: got %h want %0d", pass, drop_cnt, pass); end
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        up_c0_valid = 1'b1; up_c0_mdata = 16'h1111;
        tick();
        idle();
        up_c1_valid = 1'b1; up_c1_mdata = 16'hD222;
        tick();
        checks++; if ({afu_c0_valid, c0_rsp_cnt[63:32]} !== {9'h002, 32'd1}) begin errors++; $display("FAIL inflight_pre: got %h/%h want 002/1", afu_c0_valid, c0_rsp_cnt[63:32]); end
        idle();
        SoftReset = 1'b1;
        up_c1TxAlmFull = 1'b0;
        tick();
        checks++; if ({afu_c0_valid, afu_c1_valid} !== '0) begin errors++; $display("FAIL inflight_strobe: got %h/%h want 0", afu_c0_valid, afu_c1_valid); end
        checks++; if ({drop_cnt, c0_rsp_cnt} !== '0) begin errors++; $display("FAIL inflight_cnt: got %h/%h want 0", drop_cnt, c0_rsp_cnt); end
        checks++; if (afu_c1TxAlmFull !== {N{1'b1}}) begin errors++; $display("FAIL inflight_alm: got %h want 1ff", afu_c1TxAlmFull); end
        SoftReset = 1'b0;
        up_c0_valid = 1'b1; up_c0_mdata = 16'h4000;
        tick();
        idle();
        checks++; if ({afu_c0_valid, afu_c1_valid, drop_cnt} !== '0) begin errors++; $display("FAIL post_reset_empty: got %h/%h/%h want 0", afu_c0_valid, afu_c1_valid, drop_cnt); end
        tick();
        checks++; if ({afu_c0_valid, c0_rsp_cnt[4*32 +: 32]} !== {9'h010, 32'd1}) begin errors++; $display("FAIL post_reset_first: got %h/%h want 010/1", afu_c0_valid, c0_rsp_cnt[4*32 +: 32]); end
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.g_lane[0].u_lane.cnt = 32'hFFFF_FFFE;
        #1;
        release dut.g_lane[0].u_lane.cnt;
        for (int k = 0; k < 2; k++) begin
            up_c0_valid = 1'b1; up_c0_mdata = 16'h0F0F;
            tick(); idle(); tick();
            checks++;
            if ({afu_c0_valid, c0_rsp_cnt[31:0]} !== {9'h001, ((k == 0) ? 32'hFFFF_FFFF : 32'd0)}) begin
                errors++; $display("FAIL wrap_%0d: got %h/%h", k, afu_c0_valid, c0_rsp_cnt[31:0]);
            end
        end
    endtask

    task automatic test_random(input int n);
        exp_t        prev;
        exp_t        cur;
        exp_t        want;
        logic [31:0] mcnt [N];
        logic [31:0] mdrop;
        logic [15:0] airp;
        logic        rst_now;
        int          idx;
        int          win;
        int          mk;
        do_reset();
        prev  = '0;
        mdrop = '0;
        for (int i = 0; i < N; i++) mcnt[i] = '0;
        for (int t = 0; t < n; t++) begin
            rst_now = ($urandom_range(0, 49) == 0);
            SoftReset = rst_now;
            up_c0_valid = 1'($urandom_range(0, 1));
            up_c0_mdata = {4'($urandom_range(0, 10)), 12'($urandom())};
            up_c0_resp_type = 4'($urandom());
            up_c0_cl_num = 2'($urandom());
            for (int k = 0; k < 16; k++) up_c0_data[k*32 +: 32] = $urandom();
            up_c1_valid = 1'($urandom_range(0, 1));
            up_c1_mdata = {4'($urandom_range(0, 10)), 12'($urandom())};
            up_c1_resp_type = 4'($urandom());
            mk = $urandom_range(0, 7);
            up_mmio_rd = (mk == 3 || mk == 4 || mk == 7);
            up_mmio_wr = (mk == 5 || mk == 6 || mk == 7);
            up_mmio_addr = {4'($urandom_range(0, 11)), 12'($urandom())};
            up_mmio_tid = 9'($urandom());
            up_mmio_data = {$urandom(), $urandom()};
            for (int i = 0; i < N; i++) afu_in_reset[i] = ($urandom_range(0, 7) == 0);
            up_c0TxAlmFull = 1'($urandom_range(0, 1));
            up_c1TxAlmFull = 1'($urandom_range(0, 1));

            cur = prev;
            cur.c0v = '0; cur.c1v = '0; cur.rd = '0; cur.wr = '0;
            if (rst_now) begin
                mdrop = '0;
                for (int i = 0; i < N; i++) mcnt[i] = '0;
                cur.lv0 = 1'b0; cur.lv1 = 1'b0; cur.lvm = 1'b0;
            end else begin
                airp = 16'(afu_in_reset);
                if (up_c0_valid) begin
                    idx = int'(up_c0_mdata[15:12]);
                    if (idx < N && !airp[idx]) begin
                        cur.c0v[idx] = 1'b1;
                        mcnt[idx] = mcnt[idx] + 1;
                        cur.lv0 = 1'b1;
                        cur.c0_type = up_c0_resp_type;
                        cur.c0_md = {4'h0, up_c0_mdata[11:0]};
                        cur.c0_cl = up_c0_cl_num;
                        cur.c0_d = up_c0_data;
                    end else mdrop = mdrop + 1;
                end
                if (up_c1_valid) begin
                    idx = int'(up_c1_mdata[15:12]);
                    if (idx < N && !airp[idx]) begin
                        cur.c1v[idx] = 1'b1;
                        cur.lv1 = 1'b1;
                        cur.c1_type = up_c1_resp_type;
                        cur.c1_md = {4'h0, up_c1_mdata[11:0]};
                    end else mdrop = mdrop + 1;
                end
                win = int'(up_mmio_addr[15:12]);
                if ((up_mmio_rd || up_mmio_wr) && win != 0) begin
                    if (up_mmio_rd && up_mmio_wr) mdrop = mdrop + 1;
                    else if (win > N || airp[win-1]) mdrop = mdrop + 1;
                    else begin
                        if (up_mmio_rd) cur.rd[win-1] = 1'b1;
                        else cur.wr[win-1] = 1'b1;
                        cur.lvm = 1'b1;
                        cur.m_addr = up_mmio_addr[11:0];
                        cur.m_tid = up_mmio_tid;
                        cur.m_data = up_mmio_data;
                    end
                end
            end
            cur.drop = mdrop;
            for (int i = 0; i < N; i++) cur.cnt[i*32 +: 32] = mcnt[i];
            // an edge with reset held emits nothing and clears every counter
            want = rst_now ? exp_t'('0) : prev;
            tick();
            checks++; if (afu_c0_valid !== want.c0v) begin errors++; $display("FAIL rnd_c0v t=%0d: got %h want %h", t, afu_c0_valid, want.c0v); end
            checks++; if (afu_c1_valid !== want.c1v) begin errors++; $display("FAIL rnd_c1v t=%0d: got %h want %h", t, afu_c1_valid, want.c1v); end
            checks++; if (afu_mmio_rd !== want.rd) begin errors++; $display("FAIL rnd_rd t=%0d: got %h want %h", t, afu_mmio_rd, want.rd); end
            checks++; if (afu_mmio_wr !== want.wr) begin errors++; $display("FAIL rnd_wr t=%0d: got %h want %h", t, afu_mmio_wr, want.wr); end
            checks++; if (drop_cnt !== want.drop) begin errors++; $display("FAIL rnd_drop t=%0d: got %h want %h", t, drop_cnt, want.drop); end
            checks++; if (c0_rsp_cnt !== want.cnt) begin errors++; $display("FAIL rnd_cnt t=%0d: got %h want %h", t, c0_rsp_cnt, want.cnt); end
            checks++; if (afu_c0TxAlmFull !== (rst_now ? {N{1'b1}} : {N{up_c0TxAlmFull}})) begin errors++; $display("FAIL rnd_alm0 t=%0d: got %h", t, afu_c0TxAlmFull); end
            checks++; if (afu_c1TxAlmFull !== (rst_now ? {N{1'b1}} : {N{up_c1TxAlmFull}})) begin errors++; $display("FAIL rnd_alm1 t=%0d: got %h", t, afu_c1TxAlmFull); end
            if (want.lv0) begin
                checks++;
                if ({dn_c0_resp_type, dn_c0_mdata, dn_c0_cl_num, dn_c0_data} !== {want.c0_type, want.c0_md, want.c0_cl, want.c0_d}) begin
                    errors++; $display("FAIL rnd_c0_payload t=%0d: got %h/%h/%h want %h/%h/%h", t, dn_c0_resp_type, dn_c0_mdata, dn_c0_cl_num, want.c0_type, want.c0_md, want.c0_cl);
                end
            end
            if (want.lv1) begin
                checks++;
                if ({dn_c1_resp_type, dn_c1_mdata} !== {want.c1_type, want.c1_md}) begin
                    errors++; $display("FAIL rnd_c1_payload t=%0d: got %h/%h want %h/%h", t, dn_c1_resp_type, dn_c1_mdata, want.c1_type, want.c1_md);
                end
            end
            if (want.lvm) begin
                checks++;
                if ({dn_mmio_addr, dn_mmio_tid, dn_mmio_data} !== {want.m_addr, want.m_tid, want.m_data}) begin
                    errors++; $display("FAIL rnd_mmio_payload t=%0d: got %h/%h/%h want %h/%h/%h", t, dn_mmio_addr, dn_mmio_tid, dn_mmio_data, want.m_addr, want.m_tid, want.m_data);
                end
            end
            prev = cur;
        end
        SoftReset = 1'b0;
        idle();
    endtask

    initial begin
        SoftReset = 1'b1;
        idle();
        up_c0_resp_type = '0; up_c0_mdata = '0; up_c0_cl_num = '0; up_c0_data = '0;
        up_c1_resp_type = '0; up_c1_mdata = '0;
        up_mmio_addr = '0; up_mmio_tid = '0; up_mmio_data = '0;
        up_c0TxAlmFull = 1'b0; up_c1TxAlmFull = 1'b0;
        test_reset();
        test_c0_route();
        test_back_to_back();
        test_c1_drop();
        test_mmio();
        test_same_cycle();
        test_reset_inflight();
        test_wrap();
        test_random(600);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
